mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//   Shares one memory port between the instruction-fetch path (port A, read-only,
//   driven by cpu_icache refills) and the CPU data bus (port B, read/write).
//   Latches one request per port, grants round-robin and sequences the memory
//   handshake. Returns a one-cycle ack with read data to the winning requester.
// PARAMETERS
//   TIMEOUT   255   cycles in ISSUE+WAIT before abort (used only with MEM_ARB_TIMEOUT_EN)
// PORTS
//   clock            in   1   system clock, rising edge
//   reset            in   1   asynchronous, active-high reset
//   a_request        in   1   1-cycle pulse: instruction-side read request
//   a_addr           in   32  A address, sampled with a_request
//   a_rdata          out  32  A read data, valid while a_ack=1, held afterwards
//   a_ack            out  1   1-cycle pulse: A transaction complete
//   b_request        in   1   1-cycle pulse: data-side request
//   b_addr           in   32  B address, sampled with b_request
//   b_write          in   1   1=write, 0=read
//   b_byte_enable    in   4   B byte lanes (write only)
//   b_wdata          in   32  B write data
//   b_rdata          out  32  B read data, valid while b_ack=1, held afterwards
//   b_ack            out  1   1-cycle pulse: B transaction complete
//   mem_request      out  1   held high until mem_ready sampled high
//   mem_addr         out  32  memory address
//   mem_write        out  1   memory write strobe qualifier
//   mem_byte_enable  out  4   byte lanes (4'b1111 for A reads)
//   mem_wdata        out  32  memory write data
//   mem_ready        in   1   memory accepts request this cycle
//   mem_rdata        in   32  read data, valid with mem_rvalid
//   mem_rvalid       in   1   1-cycle pulse: read data returned
//   busy             out  1   state != IDLE or any request pending
//   timeout_err      out  1   1-cycle pulse on abort (tied 0 without macro)
// BEHAVIOUR
//   - Reset (async): state=IDLE, pend_a=pend_b=0, last_grant=A; all outputs 0.
//   - Request pulse sets pend_x and latches its fields; a request on a port already
//     pending or in service is a protocol violation and is ignored.
//   - IDLE: candidates = request inputs OR pend bits. If one candidate, grant it.
//     If both, grant the port != last_grant (B wins first contention after reset).
//     Register mem_* from the granted fields, clear its pend bit, update
//     last_grant, go ISSUE. No candidate: stay IDLE.
//   - ISSUE: mem_request=1 and mem_* stable. On mem_ready=1: drop mem_request;
//     read -> WAIT; write -> assert b_ack next cycle (posted), go IDLE.
//   - WAIT: on mem_rvalid=1, capture mem_rdata into x_rdata, pulse x_ack next cycle,
//     go IDLE. mem_rvalid in IDLE/ISSUE is ignored.
//   - Minimum latency (request in cycle c): mem_request high in c+1; read with
//     mem_ready in c+1 and mem_rvalid in c+2 -> ack in c+3; write ack in c+2.
//   - Non-granted requests wait in pend; a new request may arrive during any state.
//   - Reset mid-operation discards in-flight and pending work; no ack is issued.
//   - a_ack and b_ack are never high in the same cycle.
// CONFIGURATION
//   MEM_ARB_TIMEOUT_EN defined: 8+ bit counter clears on entry to ISSUE and counts
//   every ISSUE/WAIT cycle. On reaching TIMEOUT: drop mem_request, ack granted port
//   with rdata 32'hDEADDEAD, pulse timeout_err, go IDLE. A late mem_rvalid is ignored.
//   Not defined: no counter; ISSUE/WAIT wait indefinitely; timeout_err = 0.
// TESTING
//   1 B read 0x100, mem_ready immediate, rvalid next cycle with 0x12345678 ->
//     b_ack at c+3 with b_rdata=0x12345678; a_ack stays 0.
//   2 A read 0x200 and B read 0x300 same cycle after reset -> mem_addr=0x300 first,
//     then 0x200; each ack carries its own data; no lost request.
//   3 Both ports re-request on every ack for 8 transactions -> grant order
//     B,A,B,A,B,A,B,A.
//   4 B write 0x40, be=4'b0011, wdata 0xAABBCCDD, mem_ready delayed 3 cycles ->
//     mem_* stable for all 4 ISSUE cycles; b_ack exactly 1 cycle after acceptance.
//   5 reset asserted in WAIT -> outputs 0 without a clock edge; after release no ack;
//     busy=0; a fresh request completes normally.
//   6 MEM_ARB_TIMEOUT_EN, TIMEOUT=16, mem_ready held 0 on A read -> a_ack with
//     0xDEADDEAD and timeout_err in the same cycle, 16 cycles after ISSUE entry.
//     Without macro: still in ISSUE at cycle 100.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the instruction-fetch read
// port (A) and the CPU data read/write port (B). One request per port is
// latched, grants alternate on contention, and the memory handshake is
// sequenced through IDLE -> ISSUE -> (WAIT) -> IDLE.
// Optional build macro MEM_ARB_TIMEOUT_EN adds an abort counter: a stuck
// transaction is acked with 32'hDEADDEAD and a timeout_err pulse.
module mem_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        a_request,
  input  logic [31:0] a_addr,
  output logic [31:0] a_rdata,
  output logic        a_ack,
  input  logic        b_request,
  input  logic [31:0] b_addr,
  input  logic        b_write,
  input  logic [3:0]  b_byte_enable,
  input  logic [31:0] b_wdata,
  output logic [31:0] b_rdata,
  output logic        b_ack,
  output logic        mem_request,
  output logic [31:0] mem_addr,
  output logic        mem_write,
  output logic [3:0]  mem_byte_enable,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t      state_q, state_d;
  logic        pend_a_q, pend_a_d;
  logic        pend_b_q, pend_b_d;
  logic        last_grant_b_q, last_grant_b_d;
  logic        grant_b_q, grant_b_d;
  logic [31:0] a_addr_q, a_addr_d;
  logic [31:0] b_addr_q, b_addr_d;
  logic        b_write_q, b_write_d;
  logic [3:0]  b_be_q, b_be_d;
  logic [31:0] b_wdata_q, b_wdata_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        mem_write_q, mem_write_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] a_rdata_q, a_rdata_d;
  logic [31:0] b_rdata_q, b_rdata_d;
  logic        a_ack_q, a_ack_d;
  logic        b_ack_q, b_ack_d;
  logic        timeout_err_d;
  logic        pick_b;
  logic        service_a, service_b;

  assign service_a = (state_q != IDLE) && !grant_b_q;
  assign service_b = (state_q != IDLE) && grant_b_q;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_err_q;
  logic          done;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  // Request capture, round-robin grant and memory handshake sequencing.
  always_comb begin
    state_d        = state_q;
    pend_a_d       = pend_a_q;
    pend_b_d       = pend_b_q;
    last_grant_b_d = last_grant_b_q;
    grant_b_d      = grant_b_q;
    a_addr_d       = a_addr_q;
    b_addr_d       = b_addr_q;
    b_write_d      = b_write_q;
    b_be_d         = b_be_q;
    b_wdata_d      = b_wdata_q;
    mem_addr_d     = mem_addr_q;
    mem_write_d    = mem_write_q;
    mem_be_d       = mem_be_q;
    mem_wdata_d    = mem_wdata_q;
    a_rdata_d      = a_rdata_q;
    b_rdata_d      = b_rdata_q;
    a_ack_d        = 1'b0;
    b_ack_d        = 1'b0;
    timeout_err_d  = 1'b0;
    pick_b         = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d          = cnt_q;
    done           = 1'b0;
`endif

    if (a_request && !pend_a_q && !service_a) begin
      pend_a_d = 1'b1;
      a_addr_d = a_addr;
    end
    if (b_request && !pend_b_q && !service_b) begin
      pend_b_d  = 1'b1;
      b_addr_d  = b_addr;
      b_write_d = b_write;
      b_be_d    = b_byte_enable;
      b_wdata_d = b_wdata;
    end

    case (state_q)
      IDLE: begin
        if (pend_a_d || pend_b_d) begin
          pick_b         = pend_b_d && (!pend_a_d || !last_grant_b_q);
          grant_b_d      = pick_b;
          last_grant_b_d = pick_b;
          state_d        = ISSUE;
`ifdef MEM_ARB_TIMEOUT_EN
          cnt_d          = '0;
`endif
          if (pick_b) begin
            pend_b_d    = 1'b0;
            mem_addr_d  = b_addr_d;
            mem_write_d = b_write_d;
            mem_be_d    = b_be_d;
            mem_wdata_d = b_wdata_d;
          end else begin
            pend_a_d    = 1'b0;
            mem_addr_d  = a_addr_d;
            mem_write_d = 1'b0;
            mem_be_d    = 4'b1111;
            mem_wdata_d = 32'h0;
          end
        end
      end
      ISSUE: begin
        if (mem_ready) begin
          if (mem_write_q) begin
            b_ack_d = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          if (grant_b_q) begin
            b_rdata_d = mem_rdata;
            b_ack_d   = 1'b1;
          end else begin
            a_rdata_d = mem_rdata;
            a_ack_d   = 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef MEM_ARB_TIMEOUT_EN
    if (state_q == ISSUE || state_q == WAIT) begin
      cnt_d = cnt_q + 1'b1;
      done  = (state_q == ISSUE && mem_ready) || (state_q == WAIT && mem_rvalid);
      if (!done && cnt_q >= CW'(TIMEOUT - 1)) begin
        state_d       = IDLE;
        timeout_err_d = 1'b1;
        if (grant_b_q) begin
          b_rdata_d = 32'hDEADDEAD;
          b_ack_d   = 1'b1;
        end else begin
          a_rdata_d = 32'hDEADDEAD;
          a_ack_d   = 1'b1;
        end
      end
    end
`endif
  end

  // State and datapath registers; reset drops all in-flight and pending work.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      pend_a_q       <= 1'b0;
      pend_b_q       <= 1'b0;
      last_grant_b_q <= 1'b0;
      grant_b_q      <= 1'b0;
      a_addr_q       <= 32'h0;
      b_addr_q       <= 32'h0;
      b_write_q      <= 1'b0;
      b_be_q         <= 4'h0;
      b_wdata_q      <= 32'h0;
      mem_addr_q     <= 32'h0;
      mem_write_q    <= 1'b0;
      mem_be_q       <= 4'h0;
      mem_wdata_q    <= 32'h0;
      a_rdata_q      <= 32'h0;
      b_rdata_q      <= 32'h0;
      a_ack_q        <= 1'b0;
      b_ack_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      pend_a_q       <= pend_a_d;
      pend_b_q       <= pend_b_d;
      last_grant_b_q <= last_grant_b_d;
      grant_b_q      <= grant_b_d;
      a_addr_q       <= a_addr_d;
      b_addr_q       <= b_addr_d;
      b_write_q      <= b_write_d;
      b_be_q         <= b_be_d;
      b_wdata_q      <= b_wdata_d;
      mem_addr_q     <= mem_addr_d;
      mem_write_q    <= mem_write_d;
      mem_be_q       <= mem_be_d;
      mem_wdata_q    <= mem_wdata_d;
      a_rdata_q      <= a_rdata_d;
      b_rdata_q      <= b_rdata_d;
      a_ack_q        <= a_ack_d;
      b_ack_q        <= b_ack_d;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  // Abort counter and its error pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = timeout_err_d;
`endif

  assign mem_request     = (state_q == ISSUE);
  assign mem_addr        = mem_addr_q;
  assign mem_write       = mem_write_q;
  assign mem_byte_enable = mem_be_q;
  assign mem_wdata       = mem_wdata_q;
  assign a_rdata         = a_rdata_q;
  assign b_rdata         = b_rdata_q;
  assign a_ack           = a_ack_q;
  assign b_ack           = b_ack_q;
  assign busy            = (state_q != IDLE) || pend_a_q || pend_b_q;

endmodule
